seq_stim_ctrl: RTL and testbench
================================

// Module: seq_stim_ctrl
// PURPOSE
//   Hardware sequencer for the a/b/c/d inputs of a sequence-under-test block, such as the
//   cover_seq examples. Runs a programmable number of iterations of the pattern
//   a -> b -> [c] -> [d] -> gap, one cycle per phase. Replaces hand-written testbench
//   loops, so SVA sequences/covers can be exercised with exact, repeatable timing.
// PARAMETERS
//   CNT_W  8  width of repeat count and iteration counter
//   GAP_W  4  width of inter-iteration idle-gap length
// PORTS
//   clk        in   1      clock; all logic on posedge
//   rst_n      in   1      asynchronous, active-low reset
//   start      in   1      begin run; sampled only in IDLE
//   abort      in   1      terminate run; wins over start
//   repeat_cnt in   CNT_W  iterations to run; latched at start
//   gap_cyc    in   GAP_W  idle cycles after each iteration; latched at start
//   c_en       in   1      include C phase; latched at start
//   d_en       in   1      include D phase; latched at start
//   a,b,c,d    out  1      registered stimulus pulses to the DUT
//   busy       out  1      high from first phase through DONE
//   done       out  1      1-cycle pulse at end of run (normal or aborted)
//   aborted    out  1      1-cycle pulse, coincident with done, when run ended by abort
//   iter_cnt   out  CNT_W  completed iterations of current/last run
// BEHAVIOUR
//   Reset: all outputs 0, iter_cnt 0, FSM in IDLE. Config registers cleared.
//   FSM states and transitions:
//     IDLE -> PH_A (start & !abort & repeat_cnt!=0)
//     IDLE -> DONE (start & !abort & repeat_cnt==0)
//     PH_A -> PH_B
//     PH_B -> PH_C if c_en, else PH_D if d_en, else GAP/next
//     PH_C -> PH_D if d_en, else GAP/next
//     PH_D -> GAP/next
//     GAP counts gap_cyc cycles. gap_cyc==0 skips GAP entirely.
//     "next" at end of iteration: iter_cnt++; PH_A if iter_cnt+1 < repeat_cnt, else DONE.
//     DONE -> IDLE after one cycle.
//   Outputs are registered state decodes, exactly one cycle each:
//     a=1 in PH_A, b=1 in PH_B, c=1 in PH_C, d=1 in PH_D.
//     At most one of a/b/c/d is high in any cycle.
//   Latency: start sampled high at edge k -> a high from edge k+1 to k+2.
//   Iteration period = 2 + c_en + d_en + gap_cyc cycles.
//   busy is high in every non-IDLE state. done is high in DONE only.
//   iter_cnt clears on an accepted start and holds its value after the run.
//   Boundaries:
//     start while busy: ignored.
//     repeat_cnt = 2^CNT_W-1: full run, no counter wrap.
//     Config inputs changing mid-run: no effect (latched at start).
//     abort in any busy state (not DONE): a/b/c/d = 0 from next edge; go to DONE with
//       aborted=1; iter_cnt holds completed iterations.
//     abort in IDLE or DONE: no effect; no pulse.
//     rst_n low mid-run: immediate return to reset values; no done pulse.
// CONFIGURATION
//   SEQ_STIM_SVA_EN defined:
//     Embedded concurrent properties on the default clocking of posedge clk.
//     Assert: $onehot0({a,b,c,d}); a |=> b; done |-> busy; aborted |-> done.
//     Cover: a ##1 b; a ##1 b ##1 c ##1 d; done with iter_cnt==repeat latched.
//     All disabled iff !rst_n.
//   SEQ_STIM_SVA_EN undefined: no assertion code; identical RTL behaviour.
// STRUCTURE
//   Package seq_stim_pkg: typedef enum logic[2:0] state_t
//     {IDLE, PH_A, PH_B, PH_C, PH_D, GAP, DONE}; localparam defaults for CNT_W/GAP_W.
//   Sub-module seq_stim_gap_tmr: loadable GAP_W down-counter with zero flag; used for GAP.
//   All else lives in the single FSM module.
// TESTING
//   1. repeat_cnt=10, gap=1, c_en=d_en=0, start pulse
//      -> 10x (a, b, idle) pattern; done at cycle 31 after start; iter_cnt=10.
//   2. repeat_cnt=2, gap=0, c_en=d_en=1
//      -> a,b,c,d,a,b,c,d back-to-back; done next cycle; onehot0 holds throughout.
//   3. repeat_cnt=0, start -> no a/b/c/d; done and busy high 1 cycle after start.
//   4. repeat_cnt=5, gap=3; abort in PH_B of 3rd iteration
//      -> b low next edge; done=aborted=1; iter_cnt=2.
//   5. Second start while busy, and config changes mid-run
//      -> ignored; pattern matches originally latched config.
//   6. rst_n low during PH_C -> all outputs 0 asynchronously; IDLE; no done after release.

Source files
------------

// File: rtl/seq_stim_pkg.sv
// Shared types and default widths for the a/b/c/d stimulus sequencer.
package seq_stim_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned GAP_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    PH_D = 3'd4,
    GAP  = 3'd5,
    DONE = 3'd6
  } state_t;

endpackage

// File: rtl/seq_stim_gap_tmr.sv
// Loadable down-counter timing the idle gap after each iteration.
module seq_stim_gap_tmr
  import seq_stim_pkg::*;
#(
  parameter int unsigned GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [GAP_W-1:0] cnt_q;
  logic [GAP_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/seq_stim_ctrl.sv
// Sequencer driving a -> b -> [c] -> [d] -> gap for a programmable number of iterations.
// Define SEQ_STIM_SVA_EN to embed protocol assertions and covers.
module seq_stim_ctrl
  import seq_stim_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_cyc,
  input  logic             c_en,
  input  logic             d_en,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] iter_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             c_en_q, c_en_d;
  logic             d_en_q, d_en_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic             a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

  logic             phase_end;
  logic             iter_next;
  logic             abort_hit;
  logic             more_iter;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero_c;

  // Widened compare so a full-scale repeat count never wraps.
  assign more_iter = ((CNT_W+1)'(iter_cnt_q) + (CNT_W+1)'(1)) < (CNT_W+1)'(rep_q);

  seq_stim_gap_tmr #(.GAP_W(GAP_W)) u_gap_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (GAP_W'(gap_q - GAP_W'(1))),
    .dec      (tmr_dec),
    .zero_c   (tmr_zero_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rep_q      <= '0;
      gap_q      <= '0;
      c_en_q     <= 1'b0;
      d_en_q     <= 1'b0;
      iter_cnt_q <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      c_q        <= 1'b0;
      d_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rep_q      <= rep_d;
      gap_q      <= gap_d;
      c_en_q     <= c_en_d;
      d_en_q     <= d_en_d;
      iter_cnt_q <= iter_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    c_en_d     = c_en_q;
    d_en_d     = d_en_q;
    iter_cnt_d = iter_cnt_q;
    phase_end  = 1'b0;
    iter_next  = 1'b0;
    abort_hit  = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          rep_d      = repeat_cnt;
          gap_d      = gap_cyc;
          c_en_d     = c_en;
          d_en_d     = d_en;
          iter_cnt_d = '0;
          state_d    = (repeat_cnt != '0) ? PH_A : DONE;
        end
      end
      PH_A: state_d = PH_B;
      PH_B: begin
        if (c_en_q)      state_d = PH_C;
        else if (d_en_q) state_d = PH_D;
        else             phase_end = 1'b1;
      end
      PH_C: begin
        if (d_en_q) state_d = PH_D;
        else        phase_end = 1'b1;
      end
      PH_D: phase_end = 1'b1;
      GAP: begin
        if (tmr_zero_c) iter_next = 1'b1;
        else            tmr_dec = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Last active phase either enters the gap or closes the iteration directly.
    if (phase_end) begin
      if (gap_q != '0) begin
        state_d  = GAP;
        tmr_load = 1'b1;
      end else begin
        iter_next = 1'b1;
      end
    end

    if (iter_next) begin
      iter_cnt_d = iter_cnt_q + CNT_W'(1);
      state_d    = more_iter ? PH_A : DONE;
    end

    // Abort overrides any in-flight progress; the current iteration is not counted.
    if (abort && (state_q != IDLE) && (state_q != DONE)) begin
      state_d    = DONE;
      iter_cnt_d = iter_cnt_q;
      tmr_load   = 1'b0;
      tmr_dec    = 1'b0;
      abort_hit  = 1'b1;
    end
  end

  always_comb begin
    a_d       = (state_d == PH_A);
    b_d       = (state_d == PH_B);
    c_d       = (state_d == PH_C);
    d_d       = (state_d == PH_D);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    aborted_d = abort_hit;
  end

  assign a        = a_q;
  assign b        = b_q;
  assign c        = c_q;
  assign d        = d_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign iter_cnt = iter_cnt_q;

`ifdef SEQ_STIM_SVA_EN
  default clocking sva_cb @(posedge clk); endclocking

  ap_onehot0  : assert property (disable iff (!rst_n) $onehot0({a, b, c, d}));
  ap_a_then_b : assert property (disable iff (!rst_n) (a && !abort) |=> b);
  ap_done_bsy : assert property (disable iff (!rst_n) done |-> busy);
  ap_abt_done : assert property (disable iff (!rst_n) aborted |-> done);

  cp_ab       : cover property (disable iff (!rst_n) a ##1 b);
  cp_abcd     : cover property (disable iff (!rst_n) a ##1 b ##1 c ##1 d);
  cp_full_run : cover property (disable iff (!rst_n) done && (iter_cnt == rep_q));
`else
`endif

endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Randomized self-checking bench for seq_stim_ctrl against a phase-list reference model.
module tb_seq_stim_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] repeat_cnt;
  logic [3:0] gap_cyc;
  logic       c_en;
  logic       d_en;
  logic       a, b, c, d, busy, done, aborted;
  logic [7:0] iter_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Phase codes: 1=A 2=B 3=C 4=D 5=gap; lasts holds the last index of each iteration.
  int q[$];
  int lasts[$];

  seq_stim_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .repeat_cnt (repeat_cnt),
    .gap_cyc    (gap_cyc),
    .c_en       (c_en),
    .d_en       (d_en),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .iter_cnt   (iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] exp_vec(input int ph, input bit bsy, input bit dn, input bit ab);
    return {25'd0, ph == 1, ph == 2, ph == 3, ph == 4, bsy, dn, ab};
  endfunction

  function automatic logic [31:0] got_vec();
    return {25'd0, a, b, c, d, busy, done, aborted};
  endfunction

  function automatic int cnt_done(input int p);
    int n = 0;
    foreach (lasts[k]) if (lasts[k] < p) n++;
    return n;
  endfunction

  task automatic build(input int rep, input int gap, input bit cen, input bit den);
    q.delete();
    lasts.delete();
    for (int it = 0; it < rep; it++) begin
      q.push_back(1);
      q.push_back(2);
      if (cen) q.push_back(3);
      if (den) q.push_back(4);
      for (int g = 0; g < gap; g++) q.push_back(5);
      lasts.push_back(q.size() - 1);
    end
  endtask

  // One run: abort_pos < 0 means no abort; noise pokes start/config while busy.
  task automatic run_seq(input string tag, input int rep, input int gap, input bit cen,
                         input bit den, input int abort_pos, input bit noise);
    int  stop;
    int  ph;
    int  exp_it;
    bit  bsy, dn, ab;
    build(rep, gap, cen, den);
    stop = (abort_pos >= 0) ? abort_pos + 2 : q.size() + 1;
    @(negedge clk);
    start      = 1'b1;
    abort      = 1'b0;
    repeat_cnt = 8'(rep);
    gap_cyc    = 4'(gap);
    c_en       = cen;
    d_en       = den;
    for (int i = 1; i <= stop + 1; i++) begin
      @(posedge clk);
      #1;
      if (i < stop) begin
        ph = q[i-1]; bsy = 1'b1; dn = 1'b0; ab = 1'b0;
        exp_it = cnt_done(i - 1);
      end else begin
        ph = 0; bsy = (i == stop); dn = (i == stop); ab = (i == stop) && (abort_pos >= 0);
        exp_it = (abort_pos >= 0) ? cnt_done(abort_pos) : rep;
      end
      check({tag, "_out"}, got_vec(), exp_vec(ph, bsy, dn, ab));
      check({tag, "_iter"}, 32'(iter_cnt), 32'(exp_it));
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (noise && i <= stop) begin
        start      = 1'($urandom_range(0, 1));
        repeat_cnt = 8'($urandom);
        gap_cyc    = 4'($urandom);
        c_en       = 1'($urandom_range(0, 1));
        d_en       = 1'($urandom_range(0, 1));
        if (i == stop) abort = 1'($urandom_range(0, 1));
      end
      if (abort_pos >= 0 && i == abort_pos + 1) abort = 1'b1;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    repeat_cnt = '0;
    gap_cyc    = '0;
    c_en       = 1'b0;
    d_en       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", got_vec(), exp_vec(0, 0, 0, 0));
    check("reset_iter", 32'(iter_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_out", got_vec(), exp_vec(0, 0, 0, 0));

    run_seq("t1_ab_gap1", 10, 1, 1'b0, 1'b0, -1, 1'b0);
    run_seq("t2_abcd", 2, 0, 1'b1, 1'b1, -1, 1'b0);
    run_seq("t3_zero", 0, 2, 1'b1, 1'b0, -1, 1'b0);
    run_seq("t4_abort", 5, 3, 1'b0, 1'b0, 11, 1'b0);
    run_seq("t5_noise", 4, 2, 1'b1, 1'b0, -1, 1'b1);
    run_seq("max_rep", 255, 0, 1'b0, 1'b0, -1, 1'b0);

    // Abort together with start in IDLE is a no-op.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; repeat_cnt = 8'd3;
    @(posedge clk);
    #1;
    check("idle_abort_out", got_vec(), exp_vec(0, 0, 0, 0));
    check("idle_abort_iter", 32'(iter_cnt), 32'd255);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;

    // Asynchronous reset while in PH_C.
    @(negedge clk);
    start = 1'b1; repeat_cnt = 8'd3; gap_cyc = 4'd0; c_en = 1'b1; d_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_c", got_vec(), exp_vec(3, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", got_vec(), exp_vec(0, 0, 0, 0));
    check("async_rst_iter", 32'(iter_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_idle", got_vec(), exp_vec(0, 0, 0, 0));
    end

    for (int r = 0; r < 25; r++) begin
      int rep, gap, ap;
      bit cen, den;
      rep = $urandom_range(0, 6);
      gap = $urandom_range(0, 3);
      cen = 1'($urandom_range(0, 1));
      den = 1'($urandom_range(0, 1));
      build(rep, gap, cen, den);
      ap = -1;
      if (q.size() > 0 && $urandom_range(0, 2) == 0) ap = $urandom_range(0, q.size() - 1);
      run_seq("rand", rep, gap, cen, den, ap, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
